// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: shift mode encoding and sequencer states.
package shift_pkg;

    typedef enum logic [2:0] {
        SHL  = 3'b000,
        SHR  = 3'b001,
        ROL  = 3'b010,
        ROR  = 3'b011,
        RCL  = 3'b100,
        RCR  = 3'b101,
        ASR  = 3'b110,
        RSVD = 3'b111
    } shift_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } usr_state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step: computes the next register value and carry for a given mode.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             carry,
    input  logic             serial_in,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] q_next,
    output logic             carry_next
);

    // The reserved encoding falls through to the hold defaults.
    always_comb begin
        q_next     = q;
        carry_next = carry;
        case (mode)
            SHL: begin
                q_next     = {q[WIDTH-2:0], serial_in};
                carry_next = q[WIDTH-1];
            end
            SHR: begin
                q_next     = {serial_in, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            ROL: begin
                q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_next = q[WIDTH-1];
            end
            ROR: begin
                q_next     = {q[0], q[WIDTH-1:1]};
                carry_next = q[0];
            end
            RCL: begin
                q_next     = {q[WIDTH-2:0], carry};
                carry_next = q[WIDTH-1];
            end
            RCR: begin
                q_next     = {carry, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            ASR: begin
                q_next     = {q[WIDTH-1], q[WIDTH-1:1]};
                carry_next = q[0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-mode shift/rotate register with carry flag; a start launches N one-bit steps, one per clock.
module universal_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             c_load,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    usr_state_t       state;
    shift_mode_t      mode_q;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q          (Q),
        .carry      (carry),
        .serial_in  (serial_in),
        .mode       (mode_q),
        .q_next     (q_next),
        .carry_next (carry_next)
    );

    assign busy = (state == RUN);

    // Load always wins over start, and in RUN it aborts the operation without a done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q      <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= SHL;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        Q     <= D;
                        carry <= c_load;
                    end else if (start) begin
                        if (amount == '0) begin
                            done <= 1'b1;
                        end else begin
                            mode_q <= shift_mode_t'(mode);
                            cnt    <= amount;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        Q     <= D;
                        carry <= c_load;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        Q     <= q_next;
                        carry <= carry_next;
                        cnt   <= cnt - AW'(1);
                        if (cnt == AW'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: table of single operations scored through a queue, plus hand-written corner sequences.
module tb_universal_shift_register;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic             c_load = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [AW-1:0]    amount = '0;
    logic             serial_in = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             carry;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]       mode;
        logic [AW-1:0]    amount;
        logic [WIDTH-1:0] d;
        logic             c_in;
        logic             si;
        logic [WIDTH-1:0] exp_q;
        logic             exp_c;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             c;
        int               latency;
        int               busy_cycles;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    universal_shift_register #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .D         (D),
        .c_load    (c_load),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .serial_in (serial_in),
        .Q         (Q),
        .carry     (carry),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_reg(input logic [WIDTH-1:0] d, input logic c);
        @(negedge clock);
        load = 1'b1;
        D = d;
        c_load = c;
        @(negedge clock);
        load = 1'b0;
    endtask

    // Drives one start, pushes the expectation, waits for done and scores it.
    task automatic apply_stimulus(input string name, input logic [2:0] m, input logic [AW-1:0] amt,
                                  input logic si, input logic [WIDTH-1:0] eq, input logic ec);
        exp_t e;
        int cycles = 0;
        int busy_cycles = 0;
        bit got = 0;
        e.q = eq;
        e.c = ec;
        e.latency = int'(amt) + 1;
        e.busy_cycles = int'(amt);
        sb.push_back(e);
        mode = m;
        amount = amt;
        serial_in = si;
        start = 1'b1;
        while (!got && cycles < 40) begin
            @(negedge clock);
            start = 1'b0;
            cycles++;
            if (busy) busy_cycles++;
            if (done) got = 1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: actual=no done required=done within 40 cycles", name);
            void'(sb.pop_front());
        end else begin
            check_output(name, cycles, busy_cycles);
            @(negedge clock);
            check({name, " done_one_cycle"}, done, 0);
        end
    endtask

    task automatic check_output(input string name, input int cycles, input int busy_cycles);
        exp_t e;
        e = sb.pop_front();
        check({name, " Q"}, Q, e.q);
        check({name, " carry"}, carry, e.c);
        check({name, " latency"}, cycles, e.latency);
        check({name, " busy_cycles"}, busy_cycles, e.busy_cycles);
    endtask

    initial begin
        vecs[0]  = '{ROL,  4'd1,  8'hA5, 1'b0, 1'b0, 8'h4B, 1'b1};
        vecs[1]  = '{RCR,  4'd1,  8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{RCR,  4'd1,  8'h00, 1'b1, 1'b0, 8'h80, 1'b0};
        vecs[3]  = '{ASR,  4'd3,  8'h90, 1'b0, 1'b0, 8'hF2, 1'b0};
        vecs[4]  = '{SHL,  4'd8,  8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[5]  = '{SHR,  4'd1,  8'hA5, 1'b0, 1'b0, 8'h52, 1'b1};
        vecs[6]  = '{ROR,  4'd4,  8'hA5, 1'b0, 1'b0, 8'h5A, 1'b0};
        vecs[7]  = '{RCL,  4'd9,  8'h81, 1'b1, 1'b0, 8'h81, 1'b1};
        vecs[8]  = '{RSVD, 4'd3,  8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[9]  = '{ROL,  4'd10, 8'h81, 1'b0, 1'b0, 8'h06, 1'b0};
        vecs[10] = '{SHR,  4'd12, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{ASR,  4'd2,  8'h7F, 1'b0, 1'b0, 8'h1F, 1'b1};

        #1 reset = 1'b1;
        #2;
        check("reset Q", Q, 0);
        check("reset carry", carry, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            load_reg(vecs[i].d, vecs[i].c_in);
            check($sformatf("vec%0d loaded", i), Q, vecs[i].d);
            apply_stimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].amount, vecs[i].si,
                           vecs[i].exp_q, vecs[i].exp_c);
        end

        // Back-to-back RCR without reloading
        load_reg(8'h01, 1'b0);
        apply_stimulus("rcr_first", RCR, 4'd1, 1'b0, 8'h00, 1'b1);
        apply_stimulus("rcr_second", RCR, 4'd1, 1'b0, 8'h80, 1'b0);

        // Zero-amount start: immediate done, no busy, no change
        load_reg(8'h5A, 1'b1);
        begin
            bit saw_busy = 0;
            mode = SHL;
            amount = '0;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            if (busy) saw_busy = 1;
            check("zero done", done, 1);
            check("zero Q", Q, 8'h5A);
            check("zero carry", carry, 1);
            @(negedge clock);
            if (busy) saw_busy = 1;
            check("zero done_one_cycle", done, 0);
            check("zero busy_never", saw_busy, 0);
        end

        // Start pulsed mid-run must not restart or alter the operation
        load_reg(8'h0F, 1'b0);
        begin
            int cycles = 0;
            bit got = 0;
            mode = ROL;
            amount = 4'd3;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            cycles = 1;
            mode = SHR;
            amount = 4'd1;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            cycles = 2;
            while (!got && cycles < 40) begin
                if (done) got = 1;
                else begin
                    @(negedge clock);
                    cycles++;
                end
            end
            check("midstart latency", cycles, 4);
            check("midstart Q", Q, 8'h78);
            check("midstart carry", carry, 0);
        end

        // Load during RUN aborts with no done pulse
        load_reg(8'hA5, 1'b0);
        begin
            bit saw_done = 0;
            mode = ROR;
            amount = 4'd5;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            @(negedge clock);
            check("abort busy_running", busy, 1);
            load = 1'b1;
            D = 8'h3C;
            c_load = 1'b1;
            @(negedge clock);
            load = 1'b0;
            if (done) saw_done = 1;
            check("abort Q", Q, 8'h3C);
            check("abort carry", carry, 1);
            check("abort busy", busy, 0);
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                if (done) saw_done = 1;
            end
            check("abort no_done", saw_done, 0);
            check("abort Q_held", Q, 8'h3C);
        end

        // Asynchronous reset in the middle of a run
        load_reg(8'hC3, 1'b1);
        mode = SHL;
        amount = 4'd8;
        serial_in = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async Q", Q, 0);
        check("async carry", carry, 0);
        check("async busy", busy, 0);
        check("async done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        begin
            bit saw_activity = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clock);
                if (busy || done) saw_activity = 1;
            end
            check("async resumes_idle", saw_activity, 0);
            check("async Q_after", Q, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
